// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one 4-bit lookahead group per stage,
// inter-group carry registered between stages, valid/ready handshake with global stall.
module cla_pipe_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int G = WIDTH / 4;

    logic w_advance;
    assign w_advance = ~out_valid | out_ready;
    assign in_ready  = w_advance;

    for (genvar k = 0; k < G; k++) begin : g_stage
        logic [3:0]     w_ga, w_gb, w_p, w_g, w_s;
        logic [4:1]     w_c;
        logic           w_ci;
        logic           w_vin;
        logic [4*k+3:0] w_sum_nxt;
        logic [4*k+3:0] r_sum;
        logic           r_valid;
        logic           r_cout;

        // Stage 0 takes operands straight from the ports; b is inverted here for subtract
        if (k == 0) begin : g_src
            assign w_ga      = a[3:0];
            assign w_gb      = b[3:0] ^ {4{sub}};
            assign w_ci      = sub | cin;
            assign w_vin     = in_valid & w_advance;
            assign w_sum_nxt = w_s;
        end else begin : g_src
            assign w_ga      = g_stage[k-1].g_ops.r_opa[3:0];
            assign w_gb      = g_stage[k-1].g_ops.r_opb[3:0];
            assign w_ci      = g_stage[k-1].r_cout;
            assign w_vin     = g_stage[k-1].r_valid;
            assign w_sum_nxt = {w_s, g_stage[k-1].r_sum};
        end

        assign w_p = w_ga ^ w_gb;
        assign w_g = w_ga & w_gb;

        assign w_c[1] = w_g[0] | (w_p[0] & w_ci);
        assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_ci);
        assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                      | (w_p[2] & w_p[1] & w_p[0] & w_ci);
        assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                      | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                      | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_ci);

        assign w_s = w_p ^ {w_c[3:1], w_ci};

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_cout  <= 1'b0;
                r_sum   <= '0;
            end else if (w_advance) begin
                r_valid <= w_vin;
                r_cout  <= w_c[4];
                r_sum   <= w_sum_nxt;
            end
        end

        // Operand bits of the groups not yet evaluated ride along behind this stage
        if (k < G - 1) begin : g_ops
            localparam int NU = WIDTH - 4 * (k + 1);
            logic [NU-1:0] w_na, w_nb;
            logic [NU-1:0] r_opa, r_opb;

            if (k == 0) begin : g_first
                assign w_na = a[WIDTH-1:4];
                assign w_nb = b[WIDTH-1:4] ^ {NU{sub}};
            end else begin : g_rest
                assign w_na = g_stage[k-1].g_ops.r_opa[NU+3:4];
                assign w_nb = g_stage[k-1].g_ops.r_opb[NU+3:4];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_opa <= '0;
                    r_opb <= '0;
                end else if (w_advance) begin
                    r_opa <= w_na;
                    r_opb <= w_nb;
                end
            end
        end
    end

    // Flags get their own registers so they read 0 out of reset rather than zero=1
    logic w_ovf_nxt, w_zero_nxt;
    logic r_ovf, r_zero;
    assign w_ovf_nxt  = g_stage[G-1].w_c[4] ^ g_stage[G-1].w_c[3];
    assign w_zero_nxt = ~|g_stage[G-1].w_sum_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_advance) begin
            r_ovf  <= w_ovf_nxt;
            r_zero <= w_zero_nxt;
        end
    end

    assign out_valid = g_stage[G-1].r_valid;
    assign sum       = g_stage[G-1].r_sum;
    assign cout      = g_stage[G-1].r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub at WIDTH=16, 4 and 32 against an arithmetic model.
`timescale 1ns/1ps
module tb_cla_pipe_addsub;
    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [15:0] a, b, sum;
    logic        v4_in_valid, v4_in_ready, v4_cin, v4_sub, v4_out_valid, v4_out_ready;
    logic        v4_cout, v4_ovf, v4_zero;
    logic [3:0]  v4_a, v4_b, v4_sum;
    logic        v32_in_valid, v32_in_ready, v32_cin, v32_sub, v32_out_valid, v32_out_ready;
    logic        v32_cout, v32_ovf, v32_zero;
    logic [31:0] v32_a, v32_b, v32_sum;

    cla_pipe_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .zero(zero));

    cla_pipe_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4_in_valid), .in_ready(v4_in_ready), .a(v4_a),
        .b(v4_b), .cin(v4_cin), .sub(v4_sub), .out_valid(v4_out_valid),
        .out_ready(v4_out_ready), .sum(v4_sum), .cout(v4_cout), .ovf(v4_ovf), .zero(v4_zero));

    cla_pipe_addsub #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32_in_valid), .in_ready(v32_in_ready), .a(v32_a),
        .b(v32_b), .cin(v32_cin), .sub(v32_sub), .out_valid(v32_out_valid),
        .out_ready(v32_out_ready), .sum(v32_sum), .cout(v32_cout), .ovf(v32_ovf),
        .zero(v32_zero));

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t q16[$];
    res_t q4[$];
    res_t q32[$];

    // Reference: unsigned result and carry/borrow, plus signed range check for overflow
    function automatic res_t model(input int w, input longint unsigned av, input longint unsigned bv,
                                   input logic c, input logic s);
        res_t            r;
        longint unsigned m, u;
        longint          sa, sb, sr, half;
        m    = (64'd1 << w) - 64'd1;
        av   = av & m;
        bv   = bv & m;
        half = longint'(64'd1 << (w - 1));
        sa   = longint'(av);
        sb   = longint'(bv);
        if (sa >= half) sa = sa - 2 * half;
        if (sb >= half) sb = sb - 2 * half;
        if (s) begin
            u    = (av - bv) & m;
            r.co = (av >= bv);
            sr   = sa - sb;
        end else begin
            u    = av + bv + longint'(c);
            r.co = ((u >> w) != 0);
            u    = u & m;
            sr   = sa + sb + longint'(c);
        end
        r.s  = u[31:0];
        r.ov = (sr >= half) || (sr < -half);
        r.z  = (u == 0);
        return r;
    endfunction

    function automatic logic cur_valid(input int which);
        case (which)
            4:       return v4_out_valid;
            32:      return v32_out_valid;
            default: return out_valid;
        endcase
    endfunction

    task automatic wait_out(input int which, output int cyc);
        cyc = 0;
        while (!cur_valid(which) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!cur_valid(which)) cyc = -1;
    endtask

    task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic s);
        a = av; b = bv; cin = c; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1; sub = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, sum, cout, ovf, zero} !== 20'h0) begin
                n_fail++;
                $display("FAIL reset_state cyc%0d: got v=%b sum=%h c=%b o=%b z=%b, want all 0",
                         i, out_valid, sum, cout, ovf, zero);
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_idle: got v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_add_carry();
        int cyc;
        send16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_out(16, cyc);
        n_checks++;
        if (cyc !== 3) begin n_fail++; $display("FAIL add_latency: got %0d want 3", cyc); end
        n_checks++;
        if ({sum, cout, ovf, zero} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL add_wrap: got sum=%h c=%b o=%b z=%b want 0000 1 0 1", sum, cout, ovf, zero);
        end
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_out(16, cyc);
        n_checks++;
        if ({sum, cout, ovf, zero} !== {16'h8000, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL add_ovf: got sum=%h c=%b o=%b z=%b want 8000 0 1 0", sum, cout, ovf, zero);
        end
        send16(16'h0001, 16'h0001, 1'b1, 1'b0);
        wait_out(16, cyc);
        n_checks++;
        if ({sum, cout, ovf, zero} !== {16'h0003, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL add_cin: got sum=%h c=%b o=%b z=%b want 0003 0 0 0", sum, cout, ovf, zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_subtract();
        int cyc;
        send16(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_out(16, cyc);
        n_checks++;
        if ({sum, cout, ovf, zero} !== {16'hFFFE, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL sub_borrow: got sum=%h c=%b o=%b z=%b want fffe 0 0 0", sum, cout, ovf, zero);
        end
        send16(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_out(16, cyc);
        n_checks++;
        if ({sum, cout, ovf, zero} !== {16'h7FFF, 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL sub_ovf: got sum=%h c=%b o=%b z=%b want 7fff 1 1 0", sum, cout, ovf, zero);
        end
        send16(16'h1234, 16'h1234, 1'b0, 1'b1);
        wait_out(16, cyc);
        n_checks++;
        if ({sum, cout, ovf, zero} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL sub_zero: got sum=%h c=%b o=%b z=%b want 0000 1 0 1", sum, cout, ovf, zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int          sent = 0, got = 0, cyc = 0;
        logic        stall_prev = 1'b0;
        logic [18:0] held = '0;
        logic [15:0] na, nb;
        logic        nc, ns;
        res_t        e;
        na = 16'($urandom); nb = 16'($urandom); nc = 1'($urandom); ns = 1'($urandom);
        while ((sent < 32 || got < 32) && cyc < 1000) begin
            in_valid = (sent < 32); a = na; b = nb; cin = nc; sub = ns;
            out_ready = 1'($urandom);
            #1;
            n_checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_fail++; $display("FAIL stream_in_ready: got %b want %b", in_ready, (!out_valid || out_ready));
            end
            if (stall_prev) begin
                n_checks++;
                if ({sum, cout, ovf, zero} !== held) begin
                    n_fail++; $display("FAIL stream_stall_hold: got %h want %h", {sum, cout, ovf, zero}, held);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q16.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra: got sum=%h want no result", sum);
                end else begin
                    e = q16.pop_front();
                    if ({sum, cout, ovf, zero} !== {e.s[15:0], e.co, e.ov, e.z}) begin
                        n_fail++;
                        $display("FAIL stream_result #%0d: got %h/%b%b%b want %h/%b%b%b", got,
                                 sum, cout, ovf, zero, e.s[15:0], e.co, e.ov, e.z);
                    end
                end
                got++;
            end
            stall_prev = out_valid && !out_ready;
            held = {sum, cout, ovf, zero};
            if (in_valid && in_ready) begin
                q16.push_back(model(16, 64'(na), 64'(nb), nc, ns));
                sent++;
                na = 16'($urandom); nb = 16'($urandom); nc = 1'($urandom); ns = 1'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (got !== 32 || q16.size() !== 0) begin
            n_fail++; $display("FAIL stream_count: got %0d results, %0d left, want 32 and 0", got, q16.size());
        end
    endtask

    task automatic test_reset_midstream();
        int   cyc;
        res_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'b0; sub = i[0]; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL midrst_flush cyc%0d: got out_valid=%b want 0", i, out_valid);
            end
            @(posedge clk); #1;
        end
        send16(16'h1234, 16'h0FF0, 1'b1, 1'b0);
        wait_out(16, cyc);
        n_checks++;
        if (cyc !== 3) begin n_fail++; $display("FAIL midrst_latency: got %0d want 3", cyc); end
        e = model(16, 64'h1234, 64'h0FF0, 1'b1, 1'b0);
        n_checks++;
        if ({sum, cout, ovf, zero} !== {e.s[15:0], e.co, e.ov, e.z}) begin
            n_fail++; $display("FAIL midrst_result: got sum=%h want %h", sum, e.s[15:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width4();
        int   cyc, sent = 0, got = 0, guard = 0;
        res_t e;
        v4_out_ready = 1'b1;
        v4_a = 4'h9; v4_b = 4'h3; v4_cin = 1'b0; v4_sub = 1'b1; v4_in_valid = 1'b1;
        @(posedge clk); #1;
        v4_in_valid = 1'b0;
        wait_out(4, cyc);
        n_checks++;
        if (cyc !== 0) begin n_fail++; $display("FAIL w4_latency: got %0d want 0", cyc); end
        e = model(4, 64'h9, 64'h3, 1'b0, 1'b1);
        n_checks++;
        if ({v4_sum, v4_cout, v4_ovf, v4_zero} !== {e.s[3:0], e.co, e.ov, e.z}) begin
            n_fail++; $display("FAIL w4_single: got %h/%b%b%b want %h/%b%b%b",
                               v4_sum, v4_cout, v4_ovf, v4_zero, e.s[3:0], e.co, e.ov, e.z);
        end
        @(posedge clk); #1;
        while ((sent < 1024 || got < 1024) && guard < 3000) begin
            v4_in_valid = (sent < 1024);
            v4_a = sent[3:0]; v4_b = sent[7:4]; v4_cin = sent[8]; v4_sub = sent[9];
            #1;
            if (v4_out_valid && v4_out_ready) begin
                n_checks++;
                if (q4.size() == 0) begin
                    n_fail++; $display("FAIL w4_extra: got sum=%h want no result", v4_sum);
                end else begin
                    e = q4.pop_front();
                    if ({v4_sum, v4_cout, v4_ovf, v4_zero} !== {e.s[3:0], e.co, e.ov, e.z}) begin
                        n_fail++;
                        $display("FAIL w4_result #%0d: got %h/%b%b%b want %h/%b%b%b", got,
                                 v4_sum, v4_cout, v4_ovf, v4_zero, e.s[3:0], e.co, e.ov, e.z);
                    end
                end
                got++;
            end
            if (v4_in_valid && v4_in_ready) begin
                q4.push_back(model(4, 64'(sent & 15), 64'((sent >> 4) & 15), sent[8], sent[9]));
                sent++;
            end
            @(posedge clk); #1;
            guard++;
        end
        v4_in_valid = 1'b0;
        n_checks++;
        if (got !== 1024 || q4.size() !== 0) begin
            n_fail++; $display("FAIL w4_count: got %0d results, %0d left, want 1024 and 0", got, q4.size());
        end
    endtask

    task automatic test_width32();
        int          cyc, sent = 0, got = 0, guard = 0;
        logic [31:0] na, nb;
        logic        nc, ns;
        res_t        e;
        v32_out_ready = 1'b1;
        v32_a = 32'h7FFF_FFFF; v32_b = 32'h0000_0001; v32_cin = 1'b0; v32_sub = 1'b0;
        v32_in_valid = 1'b1;
        @(posedge clk); #1;
        v32_in_valid = 1'b0;
        wait_out(32, cyc);
        n_checks++;
        if (cyc !== 7) begin n_fail++; $display("FAIL w32_latency: got %0d want 7", cyc); end
        n_checks++;
        if ({v32_sum, v32_cout, v32_ovf, v32_zero} !== {32'h8000_0000, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL w32_single: got %h/%b%b%b want 80000000/010",
                               v32_sum, v32_cout, v32_ovf, v32_zero);
        end
        @(posedge clk); #1;
        na = $urandom; nb = $urandom; nc = 1'($urandom); ns = 1'($urandom);
        while ((sent < 200 || got < 200) && guard < 2000) begin
            v32_in_valid = (sent < 200); v32_a = na; v32_b = nb; v32_cin = nc; v32_sub = ns;
            v32_out_ready = 1'($urandom);
            #1;
            if (v32_out_valid && v32_out_ready) begin
                n_checks++;
                if (q32.size() == 0) begin
                    n_fail++; $display("FAIL w32_extra: got sum=%h want no result", v32_sum);
                end else begin
                    e = q32.pop_front();
                    if ({v32_sum, v32_cout, v32_ovf, v32_zero} !== {e.s, e.co, e.ov, e.z}) begin
                        n_fail++;
                        $display("FAIL w32_result #%0d: got %h/%b%b%b want %h/%b%b%b", got,
                                 v32_sum, v32_cout, v32_ovf, v32_zero, e.s, e.co, e.ov, e.z);
                    end
                end
                got++;
            end
            if (v32_in_valid && v32_in_ready) begin
                q32.push_back(model(32, 64'(na), 64'(nb), nc, ns));
                sent++;
                na = $urandom; nb = $urandom; nc = 1'($urandom); ns = 1'($urandom);
            end
            @(posedge clk); #1;
            guard++;
        end
        v32_in_valid = 1'b0; v32_out_ready = 1'b1;
        n_checks++;
        if (got !== 200 || q32.size() !== 0) begin
            n_fail++; $display("FAIL w32_count: got %0d results, %0d left, want 200 and 0", got, q32.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        v4_in_valid = 1'b0; v4_a = '0; v4_b = '0; v4_cin = 1'b0; v4_sub = 1'b0; v4_out_ready = 1'b1;
        v32_in_valid = 1'b0; v32_a = '0; v32_b = '0; v32_cin = 1'b0; v32_sub = 1'b0; v32_out_ready = 1'b1;
        test_reset();
        test_add_carry();
        test_subtract();
        test_stream();
        test_reset_midstream();
        test_width4();
        test_width32();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
